// File: rtl/morra_tabellone.sv
// Scoreboard downstream of the MorraCinese FSMD: tracks wins, draws, aborted games,
// the current winning streak and the valid manche of the game in progress.
module morra_tabellone #(
    parameter int CW = 8,
    parameter int SW = 4,
    parameter int MW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inizia,
    input  logic [1:0]    manche,
    input  logic [1:0]    partita,
    output logic          in_corso,
    output logic [MW-1:0] manche_valide,
    output logic [CW-1:0] vinte_primo,
    output logic [CW-1:0] vinte_secondo,
    output logic [CW-1:0] pareggi,
    output logic [CW-1:0] annullate,
    output logic [1:0]    esito,
    output logic          esito_valid,
    output logic [SW-1:0] serie,
    output logic [1:0]    serie_chi
);

    typedef enum logic [1:0] {
        ATTESA = 2'b00,
        GIOCO  = 2'b01,
        ESITO  = 2'b10
    } stato_t;

    function automatic logic [CW-1:0] inc_cw(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [SW-1:0] inc_sw(input logic [SW-1:0] v);
        return (&v) ? v : v + {{(SW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [MW-1:0] inc_mw(input logic [MW-1:0] v);
        return (&v) ? v : v + {{(MW-1){1'b0}}, 1'b1};
    endfunction

    stato_t        state_q, state_d;
    logic          in_corso_q, in_corso_d;
    logic [MW-1:0] manche_valide_q, manche_valide_d;
    logic [CW-1:0] vinte_primo_q, vinte_primo_d;
    logic [CW-1:0] vinte_secondo_q, vinte_secondo_d;
    logic [CW-1:0] pareggi_q, pareggi_d;
    logic [CW-1:0] annullate_q, annullate_d;
    logic [1:0]    esito_q, esito_d;
    logic          esito_valid_q, esito_valid_d;
    logic [SW-1:0] serie_q, serie_d;
    logic [1:0]    serie_chi_q, serie_chi_d;

    // State register and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ATTESA;
            in_corso_q      <= 1'b0;
            manche_valide_q <= {MW{1'b0}};
            vinte_primo_q   <= {CW{1'b0}};
            vinte_secondo_q <= {CW{1'b0}};
            pareggi_q       <= {CW{1'b0}};
            annullate_q     <= {CW{1'b0}};
            esito_q         <= 2'b00;
            esito_valid_q   <= 1'b0;
            serie_q         <= {SW{1'b0}};
            serie_chi_q     <= 2'b00;
        end else begin
            state_q         <= state_d;
            in_corso_q      <= in_corso_d;
            manche_valide_q <= manche_valide_d;
            vinte_primo_q   <= vinte_primo_d;
            vinte_secondo_q <= vinte_secondo_d;
            pareggi_q       <= pareggi_d;
            annullate_q     <= annullate_d;
            esito_q         <= esito_d;
            esito_valid_q   <= esito_valid_d;
            serie_q         <= serie_d;
            serie_chi_q     <= serie_chi_d;
        end
    end

    // Next-state and next-output logic; abort takes priority over a result
    always_comb begin
        state_d         = state_q;
        manche_valide_d = manche_valide_q;
        vinte_primo_d   = vinte_primo_q;
        vinte_secondo_d = vinte_secondo_q;
        pareggi_d       = pareggi_q;
        annullate_d     = annullate_q;
        esito_d         = esito_q;
        esito_valid_d   = 1'b0;
        serie_d         = serie_q;
        serie_chi_d     = serie_chi_q;
        case (state_q)
            ATTESA: begin
                if (inizia) begin
                    state_d         = GIOCO;
                    manche_valide_d = {MW{1'b0}};
                end else begin
                    state_d = ATTESA;
                end
            end
            GIOCO: begin
                if (inizia) begin
                    annullate_d     = inc_cw(annullate_q);
                    manche_valide_d = {MW{1'b0}};
                end else if (partita != 2'b00) begin
                    state_d       = ESITO;
                    esito_d       = partita;
                    esito_valid_d = 1'b1;
                    if (manche != 2'b00) begin
                        manche_valide_d = inc_mw(manche_valide_q);
                    end else begin
                        manche_valide_d = manche_valide_q;
                    end
                    case (partita)
                        2'b01: begin
                            vinte_primo_d = inc_cw(vinte_primo_q);
                            serie_d       = (serie_chi_q == 2'b01) ? inc_sw(serie_q)
                                                                   : {{(SW-1){1'b0}}, 1'b1};
                            serie_chi_d   = 2'b01;
                        end
                        2'b10: begin
                            vinte_secondo_d = inc_cw(vinte_secondo_q);
                            serie_d         = (serie_chi_q == 2'b10) ? inc_sw(serie_q)
                                                                     : {{(SW-1){1'b0}}, 1'b1};
                            serie_chi_d     = 2'b10;
                        end
                        2'b11: begin
                            pareggi_d   = inc_cw(pareggi_q);
                            serie_d     = {SW{1'b0}};
                            serie_chi_d = 2'b00;
                        end
                        default: begin
                            serie_d = serie_q;
                        end
                    endcase
                end else if (manche != 2'b00) begin
                    manche_valide_d = inc_mw(manche_valide_q);
                end else begin
                    manche_valide_d = manche_valide_q;
                end
            end
            ESITO: begin
                if (inizia) begin
                    state_d         = GIOCO;
                    manche_valide_d = {MW{1'b0}};
                end else begin
                    state_d = ATTESA;
                end
            end
            default: begin
                state_d = ATTESA;
            end
        endcase
        in_corso_d = (state_d == GIOCO);
    end

    assign in_corso      = in_corso_q;
    assign manche_valide = manche_valide_q;
    assign vinte_primo   = vinte_primo_q;
    assign vinte_secondo = vinte_secondo_q;
    assign pareggi       = pareggi_q;
    assign annullate     = annullate_q;
    assign esito         = esito_q;
    assign esito_valid   = esito_valid_q;
    assign serie         = serie_q;
    assign serie_chi     = serie_chi_q;

endmodule

// File: tb/tb_morra_tabellone.sv
// Bench for morra_tabellone: a two-mode game model (playing / not playing) is
// compared against every output on every cycle, plus literal pins per scenario.
module tb_morra_tabellone;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inizia;
    logic [1:0] manche;
    logic [1:0] partita;
    logic       in_corso;
    logic [4:0] manche_valide;
    logic [7:0] vinte_primo, vinte_secondo, pareggi, annullate;
    logic [1:0] esito;
    logic       esito_valid;
    logic [3:0] serie;
    logic [1:0] serie_chi;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state: counts held as plain integers
    bit playing, pulse;
    int m_vp, m_vs, m_par, m_ann, m_mv, m_serie;
    int m_esito, m_chi;

    always #5 clk = ~clk;

    morra_tabellone dut (
        .clk(clk), .rst_n(rst_n), .inizia(inizia), .manche(manche), .partita(partita),
        .in_corso(in_corso), .manche_valide(manche_valide), .vinte_primo(vinte_primo),
        .vinte_secondo(vinte_secondo), .pareggi(pareggi), .annullate(annullate),
        .esito(esito), .esito_valid(esito_valid), .serie(serie), .serie_chi(serie_chi)
    );

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Reference model: one game either running or not, updated from sampled inputs
    always @(posedge clk) begin
        if (!rst_n) begin
            playing <= 1'b0; pulse <= 1'b0;
            m_vp <= 0; m_vs <= 0; m_par <= 0; m_ann <= 0; m_mv <= 0;
            m_serie <= 0; m_esito <= 0; m_chi <= 0;
        end else begin
            pulse <= 1'b0;
            if (!playing) begin
                if (inizia) begin
                    playing <= 1'b1;
                    m_mv    <= 0;
                end
            end else if (inizia) begin
                m_ann <= sat(m_ann + 1, 255);
                m_mv  <= 0;
            end else if (partita != 2'b00) begin
                playing <= 1'b0;
                pulse   <= 1'b1;
                m_esito <= partita;
                m_mv    <= sat(m_mv + ((manche != 2'b00) ? 1 : 0), 31);
                if (partita == 2'b11) begin
                    m_par   <= sat(m_par + 1, 255);
                    m_serie <= 0;
                    m_chi   <= 0;
                end else begin
                    if (partita == 2'b01) m_vp <= sat(m_vp + 1, 255);
                    else                  m_vs <= sat(m_vs + 1, 255);
                    m_serie <= (m_chi == int'(partita)) ? sat(m_serie + 1, 15) : 1;
                    m_chi   <= partita;
                end
            end else if (manche != 2'b00) begin
                m_mv <= sat(m_mv + 1, 31);
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_corso", int'(in_corso), int'(playing));
            cmp("manche_valide", int'(manche_valide), m_mv);
            cmp("vinte_primo", int'(vinte_primo), m_vp);
            cmp("vinte_secondo", int'(vinte_secondo), m_vs);
            cmp("pareggi", int'(pareggi), m_par);
            cmp("annullate", int'(annullate), m_ann);
            cmp("esito", int'(esito), m_esito);
            cmp("esito_valid", int'(esito_valid), int'(pulse));
            cmp("serie", int'(serie), m_serie);
            cmp("serie_chi", int'(serie_chi), m_chi);
        end
    end

    task automatic step(input bit r, input bit iz, input logic [1:0] m, input logic [1:0] p);
        rst_n = r; inizia = iz; manche = m; partita = p;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        cmp({"lit_", name}, act, exp);
    endtask

    logic [1:0] codes [6];
    logic [1:0] rm;

    initial begin
        rst_n = 1'b0; inizia = 1'b0; manche = 2'b00; partita = 2'b00;
        // 1: reset with random inputs
        step(1'b0, 1'($urandom), 2'($urandom), 2'($urandom));
        chk_en = 1'b1;
        step(1'b0, 1'($urandom), 2'($urandom), 2'($urandom));
        lit("rst_in_corso", int'(in_corso), 0);
        lit("rst_vp", int'(vinte_primo), 0);
        lit("rst_esito_valid", int'(esito_valid), 0);
        lit("rst_serie_chi", int'(serie_chi), 0);
        step(1'b1, 1'b0, 2'b00, 2'b01);
        lit("attesa_ignores", int'(vinte_primo), 0);

        // 2: draw after 6 manche
        codes = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
        step(1'b1, 1'b1, 2'b00, 2'b00);
        lit("start_in_corso", int'(in_corso), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, codes[i], 2'b00);
        step(1'b1, 1'b0, codes[5], 2'b11);
        lit("draw_mv", int'(manche_valide), 6);
        lit("draw_par", int'(pareggi), 1);
        lit("draw_esito", int'(esito), 3);
        lit("draw_valid", int'(esito_valid), 1);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        lit("draw_valid_drop", int'(esito_valid), 0);
        lit("draw_mv_hold", int'(manche_valide), 6);

        // 3: secondo, primo, then primo with 8 valid + 3 invalid manche
        step(1'b1, 1'b1, 2'b00, 2'b00);
        step(1'b1, 1'b0, 2'b10, 2'b00);
        step(1'b1, 1'b0, 2'b10, 2'b10);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b1, 2'b00, 2'b00);
        step(1'b1, 1'b0, 2'b01, 2'b01);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, (i == 2 || i == 5 || i == 7) ? 2'b00 : 2'b11, 2'b00);
        step(1'b1, 1'b0, 2'b01, 2'b01);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        lit("g3_vp", int'(vinte_primo), 2);
        lit("g3_vs", int'(vinte_secondo), 1);
        lit("g3_serie", int'(serie), 2);
        lit("g3_chi", int'(serie_chi), 1);
        lit("g3_mv", int'(manche_valide), 8);
        lit("g3_in_corso", int'(in_corso), 0);

        // 4: abort mid-game, then abort colliding with a result
        step(1'b1, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 2'b00);
        step(1'b1, 1'b1, 2'b10, 2'b00);
        step(1'b1, 1'b0, 2'b10, 2'b00);
        step(1'b1, 1'b1, 2'b01, 2'b01);
        lit("ab_ann", int'(annullate), 2);
        lit("ab_vp", int'(vinte_primo), 2);
        lit("ab_mv", int'(manche_valide), 0);
        lit("ab_in_corso", int'(in_corso), 1);
        lit("ab_valid", int'(esito_valid), 0);
        lit("ab_serie", int'(serie), 2);

        // 5: saturate vinte_primo and serie
        for (int g = 0; g < 256; g++) begin
            step(1'b1, 1'b0, 2'b01, 2'b01);
            step(1'b1, 1'b1, 2'b00, 2'b00);
        end
        step(1'b1, 1'b0, 2'b01, 2'b01);
        lit("sat_vp", int'(vinte_primo), 255);
        lit("sat_serie", int'(serie), 15);
        lit("sat_chi", int'(serie_chi), 1);

        // 6: reset while playing with 4 valid manche
        step(1'b1, 1'b1, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b11, 2'b00);
        lit("pre_rst_mv", int'(manche_valide), 4);
        step(1'b0, 1'b0, 2'b01, 2'b01);
        lit("rst_mv", int'(manche_valide), 0);
        lit("rst_vp2", int'(vinte_primo), 0);
        lit("rst_ann", int'(annullate), 0);
        lit("rst_in_corso2", int'(in_corso), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 2'b01);
        lit("post_rst_vp", int'(vinte_primo), 0);
        lit("post_rst_valid", int'(esito_valid), 0);

        // random traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rm = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 14) == 0),
                 2'($urandom),
                 ($urandom_range(0, 7) == 0) ? rm : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
